gpio_serial_config: RTL

- Per-pad GPIO configuration register in the 1.8V domain, directly downstream of the buffered constant tie-off cells.
- The tied one/zero nets form `defaults_i`, the power-on configuration word.
- The block holds the word in a serial shift chain, which housekeeping overwrites by shifting a new frame in and strobing `load`.
- `serial_data_out` feeds the next pad in the daisy chain; `cfg_q` drives the pad's control inputs.

---
 rtl/gpio_cfg_pkg.sv | 26 ++
 rtl/gpio_cfg_shifter.sv | 57 +++++
 rtl/gpio_serial_config.sv | 96 +++++++++
 3 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration register: default width,
// bit positions of the individual control fields, and frame-fill states.
package gpio_cfg_pkg;

    localparam int CFG_WIDTH_DEFAULT = 13;

    localparam int MGMT_EN  = 0;
    localparam int OUT_DIS  = 1;
    localparam int HOLD_OVR = 2;
    localparam int INP_DIS  = 3;
    localparam int IB_SEL   = 4;
    localparam int ANA_EN   = 5;
    localparam int ANA_SEL  = 6;
    localparam int ANA_POL  = 7;
    localparam int SLOW     = 8;
    localparam int VTRIP    = 9;
    localparam int DM_LSB   = 10;
    localparam int DM_MSB   = 12;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } cfg_state_e;

endpackage

// File: rtl/gpio_cfg_shifter.sv
// Serial shift chain for one pad: shift register, saturating bit counter and
// the registered daisy-chain output (shift register MSB).
module gpio_cfg_shifter
    import gpio_cfg_pkg::*;
#(
    parameter int CFG_WIDTH = CFG_WIDTH_DEFAULT,
    parameter int CNT_W     = $clog2(CFG_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CFG_WIDTH-1:0] defaults_i,
    input  logic                 shift_en,
    input  logic                 serial_data_in,
    input  logic                 load,
    input  logic                 restore,
    output logic [CFG_WIDTH-1:0] shift_reg_o,
    output logic                 serial_data_out,
    output logic [CNT_W-1:0]     bit_cnt
);

    logic [CFG_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (restore) begin
            sr_d  = defaults_i;
            cnt_d = '0;
        end else begin
            if (shift_en) begin
                sr_d = {sr_q[CFG_WIDTH-2:0], serial_data_in};
            end
            // A load always starts a new frame; a same-cycle shift is its first bit.
            if (load) begin
                cnt_d = shift_en ? CNT_W'(1) : '0;
            end else if (shift_en && (cnt_q != CNT_W'(CFG_WIDTH))) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= defaults_i;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign shift_reg_o     = sr_q;
    assign serial_data_out = sr_q[CFG_WIDTH-1];
    assign bit_cnt         = cnt_q;

endmodule

// File: rtl/gpio_serial_config.sv
// Per-pad GPIO configuration register: holds the tie-off defaults until a
// complete serial frame is shifted in and committed with a load strobe.
module gpio_serial_config
    import gpio_cfg_pkg::*;
#(
    parameter  int CFG_WIDTH = CFG_WIDTH_DEFAULT,
    localparam int CNT_W     = $clog2(CFG_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CFG_WIDTH-1:0] defaults_i,
    input  logic                 shift_en,
    input  logic                 serial_data_in,
    input  logic                 load,
    input  logic                 restore,
    output logic                 serial_data_out,
    output logic [CFG_WIDTH-1:0] cfg_q,
    output logic                 cfg_src,
    output logic                 load_done,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     bit_cnt
);

    logic [CFG_WIDTH-1:0] shift_reg;
    logic [CFG_WIDTH-1:0] cfg_d;
    logic                 cfg_src_q, cfg_src_d;
    logic                 load_done_q, load_done_d;
    logic                 frame_err_q, frame_err_d;
    cfg_state_e           state;

    gpio_cfg_shifter #(
        .CFG_WIDTH (CFG_WIDTH),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk             (clk),
        .reset           (reset),
        .defaults_i      (defaults_i),
        .shift_en        (shift_en),
        .serial_data_in  (serial_data_in),
        .load            (load),
        .restore         (restore),
        .shift_reg_o     (shift_reg),
        .serial_data_out (serial_data_out),
        .bit_cnt         (bit_cnt)
    );

    // Frame-fill state is a pure function of the bit counter.
    always_comb begin
        if (bit_cnt == '0) begin
            state = EMPTY;
        end else if (bit_cnt == CNT_W'(CFG_WIDTH)) begin
            state = FULL;
        end else begin
            state = PARTIAL;
        end
    end

    always_comb begin
        cfg_d       = cfg_q;
        cfg_src_d   = cfg_src_q;
        frame_err_d = frame_err_q;
        load_done_d = 1'b0;
        if (restore) begin
            cfg_d       = defaults_i;
            cfg_src_d   = 1'b0;
            frame_err_d = 1'b0;
        end else if (load) begin
            if (state == FULL) begin
                cfg_d       = shift_reg;
                cfg_src_d   = 1'b1;
                load_done_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q       <= defaults_i;
            cfg_src_q   <= 1'b0;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            cfg_src_q   <= cfg_src_d;
            load_done_q <= load_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cfg_src   = cfg_src_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

endmodule
